match_ctrl: RTL
===============

# match_ctrl

Parametrised match referee for the N-player tank game. It generates the game tick and runs a round/match state machine: countdown, play, round over, match over. It credits hits to attackers and counts rounds won. It sits between the tank/bullet/collision cluster and the renderer, gating movement via `play_en` and re-initialising tanks and map via `round_reset`.

## Interface
Parameters:
- `NUM_PLAYERS`, 2: number of tanks, legal range 2..4.
- `TICK_DIV`, 3333334: clk cycles per game tick, ≥2.
- `SCORE_W`, 8: width of each hit-score counter.
- `ROUNDS_TO_WIN`, 3: rounds needed to win the match, ≥1.
- `COUNTDOWN_TICKS`, 90: game ticks spent in COUNTDOWN.
- `ROUND_OVER_TICKS`, 60: game ticks spent in ROUND_OVER.

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: reset, synchronous, active-low.
- `start` in 1: level; starts or restarts the match.
- `alive` in N: per-player alive flags.
- `hit` in N: one-cycle pulse, player i was hit.
- `hit_by` in N*PID_W: attacker id for each player i, slice i.
- `game_tick` out 1: one-cycle tick strobe.
- `play_en` out 1: high only in PLAY.
- `round_reset` out 1: one-cycle pulse that re-initialises tanks and map.
- `state` out 3: current state encoding.
- `countdown` out 8: game ticks remaining in COUNTDOWN or ROUND_OVER.
- `score` out N*SCORE_W: hit score per player.
- `rounds_won` out N*RW_W: rounds won per player.
- `round_winner` out PID_W: winner of the last round.
- `round_draw` out 1: last round ended with no survivor.
- `match_over` out 1: high in MATCH_OVER.
- `match_winner` out PID_W: player who won the match.

Derived widths: PID_W = max(1, clog2(NUM_PLAYERS)); RW_W = clog2(ROUNDS_TO_WIN+1).

## Operation
States: IDLE=0, COUNTDOWN=1, PLAY=2, ROUND_OVER=3, MATCH_OVER=4.

Tick divider:
- Counter runs 0..TICK_DIV-1, free-running from reset, in every state.
- `game_tick`=1 in the cycle the counter wraps.

IDLE:
- `start`=1 → clear all scores and rounds, pulse `round_reset`, go to COUNTDOWN.

COUNTDOWN:
- On entry, `countdown` loads COUNTDOWN_TICKS.
- Each `game_tick` decrements `countdown`; the tick that takes it to 0 moves to PLAY.
- COUNTDOWN_TICKS=0: go to PLAY on the cycle after entry.
- `alive` and `hit` are ignored.

PLAY, scoring:
- For each i with `hit[i]`=1, let a = `hit_by` slice i. If a≠i and a<NUM_PLAYERS, score[a] += 1.
- Several hits crediting the same attacker in one cycle all count (add the popcount).
- Score saturates at 2^SCORE_W−1.
- Self-hits and illegal ids are not credited.

PLAY, round end:
- Round ends when popcount(`alive`) ≤ 1.
- Exactly one survivor k: `round_winner`=k, `round_draw`=0, rounds_won[k] += 1.
- Zero survivors: `round_draw`=1, no round is credited.
- Hits in the same cycle as round end are still scored.
- Next state is ROUND_OVER, with `countdown` loaded to ROUND_OVER_TICKS.

ROUND_OVER:
- Decrement `countdown` on each tick, as in COUNTDOWN.
- On expiry, if any rounds_won = ROUNDS_TO_WIN: `match_winner` = that player, go to MATCH_OVER.
- Otherwise pulse `round_reset` and go to COUNTDOWN; scores are kept.

MATCH_OVER:
- `start`=1 → clear scores and rounds, pulse `round_reset`, go to COUNTDOWN.

Any state:
- `rstn`=0 mid-match returns to IDLE with all outputs at reset values.

## Timing
- All outputs are registered.
- State and counter updates become visible the cycle after the triggering input.
- `round_reset` is high exactly one cycle: the first cycle in COUNTDOWN.
- `play_en` is high from the cycle after the expiring tick until the cycle after round end is detected.
- Reset values:
  - `state`=IDLE.
  - all scores and rounds_won = 0.
  - `countdown`=0.
  - `game_tick`=0, `play_en`=0, `round_reset`=0, `round_draw`=0, `match_over`=0.
  - `round_winner`=0, `match_winner`=0.
  - divider counter = 0.
- The first `game_tick` is asserted TICK_DIV cycles after reset is released.

## Structure
- `match_pkg` holds:
  - the state localparams;
  - the PID_W/RW_W clog2 helper function;
  - the player-id limit MAX_PLAYERS=4.
- Sub-module `tick_divider` (parameter DIV; ports clk, rstn, tick) is natural and reusable by other game blocks.
- Per-player counters use a generate loop. Popcount and credit summation are combinational.

## Test plan
Bench settings: N=3, TICK_DIV=4, COUNTDOWN_TICKS=3, ROUND_OVER_TICKS=2, ROUNDS_TO_WIN=2.

- Reset release, `start`=0 → `game_tick` pulses every 4 cycles, first at cycle 4; `state` stays IDLE.
- `start` pulse → `round_reset` for 1 cycle. `state`=COUNTDOWN, then `countdown` runs 3,2,1. PLAY with `play_en`=1 follows the third tick.
- In PLAY, `hit`=3'b011 with attackers 2,2 → score[2]=2. A self-hit (`hit_by`[0]=0) leaves scores unchanged. Seed score[1]=254 at SCORE_W=8 and credit 2 hits to player 1 → score[1]=255.
- `alive`=3'b100 → `round_winner`=2, rounds_won[2]=1, ROUND_OVER for 2 ticks, then `round_reset` and COUNTDOWN with score retained.
- `alive` 3'b011→3'b000 in one cycle → `round_draw`=1, no round credited.
- Player 2 wins a second round → MATCH_OVER, `match_winner`=2, `match_over`=1. `start` → all scores 0, COUNTDOWN. `rstn` low mid-PLAY → IDLE with all reset values.

Source files
------------

// File: rtl/match_pkg.sv
// Shared state encodings, width helpers and player limits for the match referee.
package match_pkg;

  localparam int MAX_PLAYERS = 4;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_COUNTDOWN  = 3'd1;
  localparam logic [2:0] S_PLAY       = 3'd2;
  localparam logic [2:0] S_ROUND_OVER = 3'd3;
  localparam logic [2:0] S_MATCH_OVER = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE       = S_IDLE,
    ST_COUNTDOWN  = S_COUNTDOWN,
    ST_PLAY       = S_PLAY,
    ST_ROUND_OVER = S_ROUND_OVER,
    ST_MATCH_OVER = S_MATCH_OVER
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int pid_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // A single cycle can credit one attacker with at most MAX_PLAYERS-1 hits.
  localparam int CREDIT_W    = clog2(MAX_PLAYERS);
  localparam int ALIVE_CNT_W = clog2(MAX_PLAYERS + 1);

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: registered one-cycle strobe every DIV clocks, first one DIV cycles after reset.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == CW'(DIV - 1));
      if (cnt_q == CW'(DIV - 1)) cnt_q <= '0;
      else                       cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/match_ctrl.sv
// Match referee: game tick, round/match FSM, hit scoring and round tally for N tanks.
module match_ctrl
  import match_pkg::*;
#(
  parameter int NUM_PLAYERS      = 2,
  parameter int TICK_DIV         = 3333334,
  parameter int SCORE_W          = 8,
  parameter int ROUNDS_TO_WIN    = 3,
  parameter int COUNTDOWN_TICKS  = 90,
  parameter int ROUND_OVER_TICKS = 60,
  localparam int PID_W = pid_width(NUM_PLAYERS),
  localparam int RW_W  = clog2(ROUNDS_TO_WIN + 1)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [NUM_PLAYERS-1:0]         alive,
  input  logic [NUM_PLAYERS-1:0]         hit,
  input  logic [NUM_PLAYERS*PID_W-1:0]   hit_by,
  output logic                           game_tick,
  output logic                           play_en,
  output logic                           round_reset,
  output logic [2:0]                     state,
  output logic [7:0]                     countdown,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [NUM_PLAYERS*RW_W-1:0]    rounds_won,
  output logic [PID_W-1:0]               round_winner,
  output logic                           round_draw,
  output logic                           match_over,
  output logic [PID_W-1:0]               match_winner
);

  localparam logic [7:0] CD_INIT = 8'(COUNTDOWN_TICKS);
  localparam logic [7:0] RO_INIT = 8'(ROUND_OVER_TICKS);

  state_e                   state_q;
  logic [7:0]               cd_q;
  logic                     play_en_q;
  logic                     round_reset_q;
  logic                     round_draw_q;
  logic                     match_over_q;
  logic [PID_W-1:0]         round_winner_q;
  logic [PID_W-1:0]         match_winner_q;

  logic [ALIVE_CNT_W-1:0]   alive_cnt;
  logic [PID_W-1:0]         survivor;
  logic                     round_end;
  logic                     clear_all;
  logic                     credit_en;
  logic [NUM_PLAYERS-1:0]   is_champ;
  logic                     champ_any;
  logic [PID_W-1:0]         champ_id;

  tick_divider #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .tick (game_tick)
  );

  // Lowest-indexed alive player; only meaningful when exactly one is alive.
  always_comb begin
    alive_cnt = '0;
    survivor  = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      alive_cnt = alive_cnt + ALIVE_CNT_W'(alive[i]);
      if (alive[i]) survivor = PID_W'(i);
    end
  end

  always_comb begin
    champ_any = |is_champ;
    champ_id  = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (is_champ[i]) champ_id = PID_W'(i);
    end
  end

  assign round_end = (state_q == ST_PLAY) && (alive_cnt <= ALIVE_CNT_W'(1));
  assign credit_en = (state_q == ST_PLAY);
  assign clear_all = start && ((state_q == ST_IDLE) || (state_q == ST_MATCH_OVER));

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
    logic [CREDIT_W-1:0]         credit;
    logic [SCORE_W+CREDIT_W-1:0] sum;
    logic [SCORE_W-1:0]          score_q;
    logic [RW_W-1:0]             rounds_q;

    // Count hits this cycle attributed to player gi, excluding self-hits.
    always_comb begin
      credit = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (hit[i] && (i != gi) && (hit_by[i*PID_W +: PID_W] == PID_W'(gi)))
          credit = credit + CREDIT_W'(1);
      end
    end

    assign sum = {{CREDIT_W{1'b0}}, score_q} + {{SCORE_W{1'b0}}, credit};

    always_ff @(posedge clk) begin
      if (!rstn || clear_all) begin
        score_q  <= '0;
        rounds_q <= '0;
      end else begin
        if (credit_en)
          score_q <= (|sum[SCORE_W+CREDIT_W-1:SCORE_W]) ? '1 : sum[SCORE_W-1:0];
        if (round_end && (alive_cnt == ALIVE_CNT_W'(1)) && (survivor == PID_W'(gi)) &&
            (rounds_q != RW_W'(ROUNDS_TO_WIN)))
          rounds_q <= rounds_q + RW_W'(1);
      end
    end

    assign is_champ[gi]                   = (rounds_q == RW_W'(ROUNDS_TO_WIN));
    assign score[gi*SCORE_W +: SCORE_W]   = score_q;
    assign rounds_won[gi*RW_W +: RW_W]    = rounds_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      cd_q           <= '0;
      play_en_q      <= 1'b0;
      round_reset_q  <= 1'b0;
      round_draw_q   <= 1'b0;
      match_over_q   <= 1'b0;
      round_winner_q <= '0;
      match_winner_q <= '0;
    end else begin
      round_reset_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_MATCH_OVER: begin
          if (start) begin
            state_q        <= ST_COUNTDOWN;
            cd_q           <= CD_INIT;
            round_reset_q  <= 1'b1;
            round_draw_q   <= 1'b0;
            match_over_q   <= 1'b0;
            round_winner_q <= '0;
            match_winner_q <= '0;
          end
        end
        ST_COUNTDOWN: begin
          // A zero load means there is nothing to count: go straight to play.
          if ((cd_q == 8'd0) || (game_tick && (cd_q == 8'd1))) begin
            state_q   <= ST_PLAY;
            cd_q      <= '0;
            play_en_q <= 1'b1;
          end else if (game_tick) begin
            cd_q <= cd_q - 8'd1;
          end
        end
        ST_PLAY: begin
          if (round_end) begin
            state_q      <= ST_ROUND_OVER;
            play_en_q    <= 1'b0;
            cd_q         <= RO_INIT;
            round_draw_q <= (alive_cnt == '0);
            if (alive_cnt == ALIVE_CNT_W'(1)) round_winner_q <= survivor;
          end
        end
        ST_ROUND_OVER: begin
          if ((cd_q == 8'd0) || (game_tick && (cd_q == 8'd1))) begin
            if (champ_any) begin
              state_q        <= ST_MATCH_OVER;
              cd_q           <= '0;
              match_over_q   <= 1'b1;
              match_winner_q <= champ_id;
            end else begin
              state_q       <= ST_COUNTDOWN;
              cd_q          <= CD_INIT;
              round_reset_q <= 1'b1;
            end
          end else if (game_tick) begin
            cd_q <= cd_q - 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state        = state_q;
  assign countdown    = cd_q;
  assign play_en      = play_en_q;
  assign round_reset  = round_reset_q;
  assign round_draw   = round_draw_q;
  assign match_over   = match_over_q;
  assign round_winner = round_winner_q;
  assign match_winner = match_winner_q;

endmodule
